vga_timing_gen: RTL

Raster timing generator and video output stage for the 800x600 @ 56 Hz display driven from the 36 MHz pixel clock. It produces the `h_coord`/`v_coord` pixel coordinates consumed by the game/render logic, takes back that logic's combinational 4-bit RGB, and registers it together with HSYNC/VSYNC so that colour and sync leave the FPGA aligned. It also emits frame and line markers and, optionally, a built-in colour-bar test pattern.

---
 rtl/vga_pkg.sv | 24 ++
 rtl/vga_axis_counter.sv | 66 ++++++
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing constants and phase type for the VGA raster generator
// Contents: default 800x600@56Hz timing, derived line/frame totals, axis phase enum.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 24;
  localparam int DEF_H_SYNC   = 72;
  localparam int DEF_H_BP     = 128;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 22;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FP,
    PH_SYNC,
    PH_BP
  } vga_phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter plus ACTIVE/FP/SYNC/BP phase FSM
// Ports:
//   pixel_clk, rst_n : clock, synchronous active-low reset
//   adv              : advance enable (1 for horizontal, line-end for vertical)
//   count            : current position, 0..TOTAL-1
//   phase            : phase of the current position
//   wrap             : advancing from the last position this cycle
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int W      = 11
) (
  input  logic         pixel_clk,
  input  logic         rst_n,
  input  logic         adv,
  output logic [W-1:0] count,
  output vga_phase_e   phase,
  output logic         wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  // Transitions fire on the last count of each phase so the registered
  // phase always matches the registered count.
  localparam logic [W-1:0] ACT_LAST  = W'(ACTIVE - 1);
  localparam logic [W-1:0] FP_LAST   = W'(ACTIVE + FP - 1);
  localparam logic [W-1:0] SYNC_LAST = W'(ACTIVE + FP + SYNC - 1);
  localparam logic [W-1:0] TOT_LAST  = W'(TOTAL - 1);

  logic [W-1:0] count_q, count_d;
  vga_phase_e   phase_q, phase_d;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      count_q <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    wrap    = adv && (count_q == TOT_LAST);
    count_d = count_q;
    phase_d = phase_q;
    if (adv) begin
      count_d = wrap ? '0 : count_q + W'(1);
      case (phase_q)
        PH_ACTIVE: if (count_q == ACT_LAST)  phase_d = PH_FP;
        PH_FP:     if (count_q == FP_LAST)   phase_d = PH_SYNC;
        PH_SYNC:   if (count_q == SYNC_LAST) phase_d = PH_BP;
        PH_BP:     if (wrap)                 phase_d = PH_ACTIVE;
        default:                             phase_d = PH_ACTIVE;
      endcase
    end
  end

  assign count = count_q;
  assign phase = phase_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 800x600 raster timing generator with registered colour/sync output stage
// Ports:
//   pixel_clk, rst_n             : pixel clock, synchronous active-low reset
//   red_in, green_in, blue_in    : render colour for the current h_coord/v_coord
//   test_en                      : select colour-bar pattern (only with VGA_TEST_PATTERN_EN)
//   h_coord, v_coord, display_on : raster position and active-area flag
//   line_start, frame_start      : markers at h_coord==0 / (0,0)
//   hsync, vsync, vga_r/g/b      : registered outputs, 1-cycle latency from coordinates
// Optional macro: VGA_TEST_PATTERN_EN enables the 8-bar colour pattern.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [3:0]  red_in,
  input  logic [3:0]  green_in,
  input  logic [3:0]  blue_in,
  input  logic        test_en,
  output logic [10:0] h_coord,
  output logic [9:0]  v_coord,
  output logic        display_on,
  output logic        line_start,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  vga_phase_e h_phase, v_phase;
  logic       h_wrap;
  logic       v_wrap_unused;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(11)
  ) u_h_axis (
    .pixel_clk(pixel_clk),
    .rst_n    (rst_n),
    .adv      (1'b1),
    .count    (h_coord),
    .phase    (h_phase),
    .wrap     (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(10)
  ) u_v_axis (
    .pixel_clk(pixel_clk),
    .rst_n    (rst_n),
    .adv      (h_wrap),
    .count    (v_coord),
    .phase    (v_phase),
    .wrap     (v_wrap_unused)
  );

  assign display_on  = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
  assign line_start  = (h_coord == 11'd0);
  assign frame_start = (h_coord == 11'd0) && (v_coord == 10'd0);

  logic [3:0] src_r, src_g, src_b;

`ifdef VGA_TEST_PATTERN_EN
  // Bar index = h_coord/100 via a comparator chain instead of a divider.
  logic [2:0] bar;
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_coord >= 11'(k * 100)) bar = 3'(k);
    end
  end

  always_comb begin
    src_r = red_in;
    src_g = green_in;
    src_b = blue_in;
    if (test_en) begin
      src_r = {4{bar[0]}};
      src_g = {4{bar[1]}};
      src_b = {4{bar[2]}};
    end
  end
`else
  logic test_en_unused;
  assign test_en_unused = test_en;
  assign src_r = red_in;
  assign src_g = green_in;
  assign src_b = blue_in;
`endif

  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic [3:0] vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;

  always_comb begin
    hsync_d = (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    vga_r_d = display_on ? src_r : 4'h0;
    vga_g_d = display_on ? src_g : 4'h0;
    vga_b_d = display_on ? src_b : 4'h0;
  end

  // Colour and sync share this one stage so they leave the chip aligned.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      vga_r_q <= 4'h0;
      vga_g_q <= 4'h0;
      vga_b_q <= 4'h0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      vga_r_q <= vga_r_d;
      vga_g_q <= vga_g_d;
      vga_b_q <= vga_b_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign vga_r = vga_r_q;
  assign vga_g = vga_g_q;
  assign vga_b = vga_b_q;

endmodule
